pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
- Parametrised, pipelined successor to the fixed 24-bit combinational adder used in the sincos datapath.
- Adds or subtracts two WIDTH-bit operands with carry-in, splitting the carry chain into STAGES registered chunks so wide CORDIC accumulators meet timing.
- Has a valid/ready handshake on both sides with per-stage bubble collapse, and reports carry-out and signed overflow.
- Sits between the CORDIC shift/select logic and the angle/coordinate accumulators.

Parameters:
- WIDTH, 24, operand and result width in bits; must be divisible by STAGES.
- STAGES, 3, number of pipeline stages and carry-chain chunks, 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- io_in_valid  input  1  input operands valid.
- io_in_ready  output  1  stage 0 can accept this cycle.
- io_in_a  input  WIDTH  operand A.
- io_in_b  input  WIDTH  operand B.
- io_in_cin  input  1  carry-in; borrow-in when subtracting.
- io_in_sub  input  1  0 selects add, 1 selects subtract.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  downstream accepts the result.
- io_out_s  output  WIDTH  result.
- io_out_c  output  1  carry-out; for subtract, 1 means no borrow.
- io_out_v  output  1  two's-complement signed overflow.

Behaviour:
- Transfers: input transfer when io_in_valid and io_in_ready; output transfer when io_out_valid and io_out_ready.
- Operand transform at entry: b' = io_in_sub ? ~io_in_b : io_in_b; c0 = io_in_sub ? ~io_in_cin : io_in_cin.
- Result: {c, s} = a + b' + c0, computed modulo 2^WIDTH with carry out of bit WIDTH-1.
  - Add: s = a + b + cin.
  - Subtract: s = a - b - cin.
- Chunk k (0 = least significant) is summed in stage k, using the carry registered by stage k-1. Stage 0 uses c0.
- Each stage register holds: valid bit, completed low sum chunks, remaining upper chunks of a and b', running carry, and sign bits a[W-1] and b'[W-1] for overflow.
- Overflow: v = (a[W-1] == b'[W-1]) and (s[W-1] != a[W-1]).
- Latency is exactly STAGES cycles from input transfer to io_out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stall rule: stage k loads when stage k is empty or stage k advances. Stage k advances when stage k+1 loads. The last stage advances on an output transfer.
  - io_in_ready = !valid[0] || advance[0]. This is combinational from io_out_ready through the chain.
  - Bubbles collapse: an empty stage always loads from the stage before it, even when downstream is stalled.
- Capacity is STAGES results. With io_out_ready held low, exactly STAGES inputs are accepted, then io_in_ready = 0.
- A stalled output holds io_out_s, io_out_c and io_out_v stable until it transfers.
- A simultaneous input transfer and output transfer on a full pipe shifts every stage by one; no entry is lost or duplicated.
- io_in_sub and io_in_cin are sampled per transaction only. Mixed add/sub traffic is legal back-to-back.
- Reset (asynchronous assert, synchronous-to-clock deassert by the system): all valid bits clear, io_out_valid = 0, io_in_ready = 1.
  - io_out_s, io_out_c and io_out_v reset to 0.
  - Data registers also reset to 0.
  - Reset mid-operation discards all in-flight entries.
- STAGES = 1 degenerates to one registered full-width adder stage with latency 1.
- WIDTH % STAGES != 0 is an elaboration error.

Decomposition:
- Shared package holds:
  - localparam CW = WIDTH/STAGES;
  - a function for the overflow formula;
  - a typedef for the stage payload struct {valid, sum_lo, a_hi, b_hi, carry, sa, sb}.
- One natural sub-module: full_adder_chunk, a combinational CW-bit adder with cin and cout. It is instantiated STAGES times, once per stage.

Test Plan (WIDTH=24, STAGES=3, io_out_ready=1 unless stated):
- Add a=0xFFFFFF, b=0x000001, cin=0 -> after 3 cycles s=0x000000, c=1, v=0.
- Add a=0x00FFFF, b=0x000001 (carry crosses chunk boundaries) -> s=0x010000, c=0, v=0. Add a=0x7FFFFF, b=0x000001 -> s=0x800000, c=0, v=1.
- Subtract a=0x000005, b=0x000007, cin=0 -> s=0xFFFFFE, c=0, v=0. Subtract a=0x800000, b=0x000001 -> s=0x7FFFFF, c=1, v=1. Subtract a=9, b=4, cin=1 -> s=0x000004, c=1.
- Backpressure: hold io_out_ready=0 and drive 5 back-to-back adds (i+1 plus 0x10 for i=0..4) -> exactly 3 accepted and io_in_ready=0. Release ready -> outputs 0x11, 0x12, 0x13, 0x14, 0x15 in order with no gaps after the pipe refills.
- Bubble: inputs on cycles 0 and 2 with ready low from cycle 3 -> both entries pack into the last two stages, io_in_ready stays 1, and results emerge in order.
- Reset: assert reset low with 2 entries in flight -> io_out_valid=0, io_out_s=0, io_in_ready=1 immediately. After release, the next input yields the correct result 3 cycles later and no stale results appear.

Source files
------------

// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined add/sub datapath.
package pipelined_add_sub_pkg;

    localparam int unsigned DEF_WIDTH  = 24;
    localparam int unsigned DEF_STAGES = 3;

    // Width-independent control part of every stage payload.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sa;
        logic sb;
    } stage_ctl_t;

    // Chunk width handled by each stage (CW = WIDTH/STAGES).
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

    // Two's-complement overflow from the operand signs and the result sign.
    function automatic logic signed_overflow(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

endpackage

// File: rtl/full_adder_chunk.sv
// Combinational CW-bit adder with carry-in and carry-out.
module full_adder_chunk #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_cin,
    output logic [CW-1:0] o_s_c,
    output logic          o_cout_c
);

    localparam int unsigned SW = CW + 1;

    logic [CW:0] w_sum;

    // One extra bit captures the carry out of the chunk.
    assign w_sum    = SW'(i_a) + SW'(i_b) + SW'(i_cin);
    assign o_s_c    = w_sum[CW-1:0];
    assign o_cout_c = w_sum[CW];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: carry chain split into STAGES registered chunks,
// valid/ready on both sides with bubble collapse.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_cin,
    input  logic             io_in_sub,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_s,
    output logic             io_out_c,
    output logic             io_out_v
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    // Reject geometries the chunked carry chain cannot represent.
    if (STAGES == 0 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_geometry
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
    end

    // sum_lo fills from the top, one chunk per stage, so after the last
    // stage chunk 0 sits at the LSB. a_hi/b_hi shift down so the chunk to
    // be summed next is always at the LSB.
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum_lo;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
    } stage_t;

    stage_t            r_st  [STAGES];
    stage_t            w_src [STAGES];
    stage_t            w_nxt [STAGES];
    logic [STAGES-1:0] w_load;
    logic [WIDTH-1:0]  w_b_in;
    logic              w_c0;

    // Subtract is a + ~b + ~cin; borrow-in inverts into carry-in.
    assign w_b_in = io_in_sub ? ~io_in_b : io_in_b;
    assign w_c0   = io_in_sub ? ~io_in_cin : io_in_cin;

    // Load enables: a stage loads when empty or when its contents move on.
    always_comb begin : p_load_chain
        logic w_chain;
        w_load  = '0;
        w_chain = r_st[STAGES-1].ctl.valid && io_out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_load[k] = !r_st[k].ctl.valid || w_chain;
            w_chain   = w_load[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW-1:0] w_sum;
        logic          w_cout;

        // Stage source: the input port for stage 0, the previous register otherwise.
        if (k == 0) begin : g_entry
            assign w_src[0] = '{
                ctl:    '{valid: io_in_valid, carry: w_c0,
                          sa: io_in_a[WIDTH-1], sb: w_b_in[WIDTH-1]},
                sum_lo: '0,
                a_hi:   io_in_a,
                b_hi:   w_b_in
            };
        end else begin : g_link
            assign w_src[k] = r_st[k-1];
        end

        full_adder_chunk #(
            .CW(CW)
        ) u_chunk (
            .i_a      (w_src[k].a_hi[CW-1:0]),
            .i_b      (w_src[k].b_hi[CW-1:0]),
            .i_cin    (w_src[k].ctl.carry),
            .o_s_c    (w_sum),
            .o_cout_c (w_cout)
        );

        // Next payload: new chunk enters at the top of sum_lo, operands shift down.
        assign w_nxt[k] = '{
            ctl:    '{valid: w_src[k].ctl.valid, carry: w_cout,
                      sa: w_src[k].ctl.sa, sb: w_src[k].ctl.sb},
            sum_lo: WIDTH'({w_sum, w_src[k].sum_lo} >> CW),
            a_hi:   w_src[k].a_hi >> CW,
            b_hi:   w_src[k].b_hi >> CW
        };
    end

    // Stage registers: load when enabled, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_st[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_st[k] <= w_nxt[k];
                end
            end
        end
    end

    assign io_in_ready  = w_load[0];
    assign io_out_valid = r_st[STAGES-1].ctl.valid;
    assign io_out_s     = r_st[STAGES-1].sum_lo;
    assign io_out_c     = r_st[STAGES-1].ctl.carry;
    assign io_out_v     = signed_overflow(r_st[STAGES-1].ctl.sa, r_st[STAGES-1].ctl.sb,
                                          r_st[STAGES-1].sum_lo[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=24, STAGES=3).
module tb_pipelined_add_sub;

    localparam int unsigned W = 24;
    localparam int          LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         io_in_valid = 1'b0;
    logic         io_in_ready;
    logic [W-1:0] io_in_a = '0;
    logic [W-1:0] io_in_b = '0;
    logic         io_in_cin = 1'b0;
    logic         io_in_sub = 1'b0;
    logic         io_out_valid;
    logic         io_out_ready = 1'b1;
    logic [W-1:0] io_out_s;
    logic         io_out_c;
    logic         io_out_v;

    pipelined_add_sub #(.WIDTH(W), .STAGES(3)) dut (
        .clock        (clk),
        .reset        (rst_n),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_a      (io_in_a),
        .io_in_b      (io_in_b),
        .io_in_cin    (io_in_cin),
        .io_in_sub    (io_in_sub),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_s     (io_out_s),
        .io_out_c     (io_out_c),
        .io_out_v     (io_out_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           tin;
        logic         timed;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   bp_mode = 0;   // 0: ready high, 1: ready low, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint ua, ub, sa, sbv, full, r;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!sub) begin
            full = ua + ub + longint'(cin);
            r    = sa + sbv + longint'(cin);
            e.c  = (full >= 64'sd16777216);
        end else begin
            full = ua - ub - longint'(cin);
            r    = sa - sbv - longint'(cin);
            e.c  = (ua >= ub + longint'(cin));
        end
        e.s     = W'(full);
        e.v     = (r > 64'sd8388607) || (r < -64'sd8388608);
        e.tin   = 0;
        e.timed = 1'b0;
        return e;
    endfunction

    task automatic push_exp(input logic timed);
        exp_t e;
        e       = model(io_in_a, io_in_b, io_in_cin, io_in_sub);
        e.tin   = cyc;
        e.timed = timed;
        sb_q.push_back(e);
    endtask

    // Downstream ready generator.
    always begin
        @(negedge clk);
        #1;
        case (bp_mode)
            0:       io_out_ready = 1'b1;
            1:       io_out_ready = 1'b0;
            default: io_out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops the scoreboard on every output transfer, checks stall stability.
    logic         held_valid = 1'b0;
    logic [W-1:0] held_s;
    logic         held_c, held_v;
    exp_t         mon_e;

    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("stall_valid", 32'(io_out_valid), 32'd1);
                check("stall_s", 32'(io_out_s), 32'(held_s));
                check("stall_c", 32'(io_out_c), 32'(held_c));
                check("stall_v", 32'(io_out_v), 32'(held_v));
            end
            if (io_out_valid && io_out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got s=0x%0h, required no output", io_out_s);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sum", 32'(io_out_s), 32'(mon_e.s));
                    check("carry", 32'(io_out_c), 32'(mon_e.c));
                    check("ovf", 32'(io_out_v), 32'(mon_e.v));
                    if (mon_e.timed) check("latency", 32'(cyc - mon_e.tin), 32'(LAT));
                end
                held_valid = 1'b0;
            end else if (io_out_valid) begin
                held_valid = 1'b1;
                held_s     = io_out_s;
                held_c     = io_out_c;
                held_v     = io_out_v;
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    // Offer one transaction (called at a falling edge) and wait until accepted.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic timed);
        int n = 0;
        io_in_a = a; io_in_b = b; io_in_cin = cin; io_in_sub = sub;
        io_in_valid = 1'b1;
        #4;
        while (!io_in_ready && n < 200) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (io_in_ready) push_exp(timed);
        else begin
            n_checks++;
            $display("FAIL send_timeout: got io_in_ready=0, required 1 within 200 cycles");
        end
        @(negedge clk);
        io_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, acc;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(io_out_valid), 32'd0);
        check("rst_in_ready", 32'(io_in_ready), 32'd1);
        check("rst_out_s", 32'(io_out_s), 32'd0);
        check("rst_out_c", 32'(io_out_c), 32'd0);
        check("rst_out_v", 32'(io_out_v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases, no backpressure
        send(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 1'b1);
        send(24'h00FFFF, 24'h000001, 1'b0, 1'b0, 1'b1);
        send(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 1'b1);
        send(24'h000005, 24'h000007, 1'b0, 1'b1, 1'b1);
        send(24'h800000, 24'h000001, 1'b0, 1'b1, 1'b1);
        send(24'h000009, 24'h000004, 1'b1, 1'b1, 1'b1);
        send(24'h800000, 24'h800000, 1'b0, 1'b0, 1'b1);
        send(24'h000000, 24'h000000, 1'b1, 1'b1, 1'b1);
        drain();

        // Backpressure: only three entries fit while downstream is stalled
        bp_mode = 1;
        idx = 0; acc = 0;
        io_in_a = 24'(idx + 1); io_in_b = 24'h10; io_in_cin = 1'b0; io_in_sub = 1'b0;
        io_in_valid = 1'b1;
        repeat (8) begin
            #4;
            if (io_in_ready && idx < 5) begin push_exp(1'b0); acc++; idx++; end
            @(negedge clk);
            io_in_a = 24'(idx + 1);
        end
        #4;
        check("bp_accepted", 32'(acc), 32'd3);
        check("bp_in_ready", 32'(io_in_ready), 32'd0);
        @(negedge clk);
        bp_mode = 0;
        for (int cy = 0; cy < 40 && idx < 5; cy++) begin
            io_in_a = 24'(idx + 1);
            #4;
            if (io_in_ready) begin push_exp(1'b0); idx++; end
            @(negedge clk);
        end
        io_in_valid = 1'b0;
        check("bp_all_sent", 32'(idx), 32'd5);
        drain();

        // Bubble collapse: inputs on cycles 0 and 2, downstream stalls from cycle 3
        io_in_a = 24'h000123; io_in_b = 24'h000456; io_in_cin = 1'b0; io_in_sub = 1'b0;
        io_in_valid = 1'b1;
        #4;
        check("bubble_a_ready", 32'(io_in_ready), 32'd1);
        if (io_in_ready) push_exp(1'b0);
        @(negedge clk);
        io_in_valid = 1'b0;
        @(negedge clk);
        io_in_a = 24'h00ABCD; io_in_b = 24'h000111; io_in_sub = 1'b1;
        io_in_valid = 1'b1;
        #4;
        check("bubble_b_ready", 32'(io_in_ready), 32'd1);
        if (io_in_ready) push_exp(1'b0);
        @(negedge clk);
        io_in_valid = 1'b0;
        bp_mode = 1;
        repeat (4) begin
            #4;
            check("bubble_in_ready", 32'(io_in_ready), 32'd1);
            check("bubble_out_held", 32'(io_out_valid), 32'd1);
            @(negedge clk);
        end
        bp_mode = 0;
        #4;
        check("bubble_first_out", 32'(io_out_valid), 32'd1);
        @(negedge clk);
        #4;
        check("bubble_second_out", 32'(io_out_valid), 32'd1);
        @(negedge clk);
        drain();

        // Reset with two entries in flight
        send(24'h111111, 24'h222222, 1'b0, 1'b0, 1'b0);
        send(24'h333333, 24'h000001, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(io_out_valid), 32'd0);
        check("midrst_out_s", 32'(io_out_s), 32'd0);
        check("midrst_in_ready", 32'(io_in_ready), 32'd1);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            #4;
            check("postrst_no_stale", 32'(io_out_valid), 32'd0);
            @(negedge clk);
        end
        send(24'h0000FF, 24'h000001, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomized mixed traffic with random backpressure
        bp_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
        end
        bp_mode = 0;
        drain();
        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
